// File: rtl/fetch_ctrl.sv
// fetch_ctrl: fetch-stage PC source arbiter.
// Chooses between boot vector, execute branch, interrupt entry/return,
// decode jump and stall hold, and drives the PC load plus IF/ID flushes.
// PC load controls are combinational so the PC register reloads on the
// same edge the request is seen; bookkeeping state is registered.
module fetch_ctrl #(
  parameter int unsigned       AW        = 11,
  parameter logic [AW-1:0]     RESET_VEC = 11'h000,
  parameter logic [AW-1:0]     IRQ_VEC   = 11'h7F0,
  parameter int unsigned       CW        = 16
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic [AW-1:0] pc_cnt,
  input  logic          stall,
  input  logic          ex_branch_valid,
  input  logic [AW-1:0] ex_branch_target,
  input  logic          iret,
  input  logic          id_jump_valid,
  input  logic [AW-1:0] id_jump_target,
  input  logic          irq_req,
  output logic          pc_branch_valid,
  output logic [AW-1:0] pc_branch_address,
  output logic          flush_if,
  output logic          flush_id,
  output logic          irq_ack,
  output logic          in_isr,
  output logic [AW-1:0] epc,
  output logic [CW-1:0] redirect_cnt
);

  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_RUN  = 2'd1,
    ST_ISR  = 2'd2
  } state_t;

  state_t state;
  state_t state_next;

  // One-hot winner of the per-cycle priority arbitration.
  logic take_iret;
  logic take_branch;
  logic take_irq;
  logic take_jump;
  logic take_hold;
  logic redirect;

  localparam logic [CW-1:0] CNT_MAX = {CW{1'b1}};

  // Resolve which PC source wins this cycle (fixed priority, BOOT ignores all).
  always_comb begin
    take_iret   = 1'b0;
    take_branch = 1'b0;
    take_irq    = 1'b0;
    take_jump   = 1'b0;
    take_hold   = 1'b0;
    if (state == ST_RUN || state == ST_ISR) begin
      if (iret && state == ST_ISR) begin
        take_iret = 1'b1;
      end else if (ex_branch_valid) begin
        take_branch = 1'b1;
      end else if (irq_req && state == ST_RUN && !stall && !id_jump_valid) begin
        take_irq = 1'b1;
      end else if (id_jump_valid && !stall) begin
        take_jump = 1'b1;
      end else if (stall) begin
        take_hold = 1'b1;
      end else begin
        take_hold = 1'b0;
      end
    end else begin
      take_hold = 1'b0;
    end
    redirect = take_iret | take_branch | take_irq | take_jump;
  end

  // State register; reset parks the sequencer in BOOT.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= ST_BOOT;
    end else begin
      state <= state_next;
    end
  end

  // Next-state: BOOT lasts one edge, interrupt entry/return move RUN<->ISR.
  always_comb begin
    state_next = ST_BOOT;
    case (state)
      ST_BOOT: state_next = ST_RUN;
      ST_RUN:  state_next = take_irq ? ST_ISR : ST_RUN;
      ST_ISR:  state_next = take_iret ? ST_RUN : ST_ISR;
      default: state_next = ST_BOOT;
    endcase
  end

  // PC load and flush outputs for the current state and winning source.
  always_comb begin
    pc_branch_valid   = 1'b0;
    pc_branch_address = pc_cnt;
    flush_if          = 1'b0;
    flush_id          = 1'b0;
    case (state)
      ST_RUN, ST_ISR: begin
        if (take_iret) begin
          pc_branch_valid   = 1'b1;
          pc_branch_address = epc;
          flush_if          = 1'b1;
          flush_id          = 1'b1;
        end else if (take_branch) begin
          pc_branch_valid   = 1'b1;
          pc_branch_address = ex_branch_target;
          flush_if          = 1'b1;
          flush_id          = 1'b1;
        end else if (take_irq) begin
          pc_branch_valid   = 1'b1;
          pc_branch_address = IRQ_VEC;
          flush_if          = 1'b1;
        end else if (take_jump) begin
          pc_branch_valid   = 1'b1;
          pc_branch_address = id_jump_target;
          flush_if          = 1'b1;
        end else if (take_hold) begin
          pc_branch_valid   = 1'b1;
          pc_branch_address = pc_cnt;
        end else begin
          pc_branch_valid   = 1'b0;
        end
      end
      default: begin
        pc_branch_valid   = 1'b1;
        pc_branch_address = RESET_VEC;
      end
    endcase
  end

  // Return address capture, acknowledge pulse and saturating redirect count.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      epc          <= {AW{1'b0}};
      irq_ack      <= 1'b0;
      redirect_cnt <= {CW{1'b0}};
    end else begin
      irq_ack <= take_irq;
      if (take_irq) begin
        epc <= pc_cnt;
      end
      if (redirect && redirect_cnt != CNT_MAX) begin
        redirect_cnt <= redirect_cnt + {{(CW-1){1'b0}}, 1'b1};
      end
    end
  end

  assign in_isr = (state == ST_ISR);

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl (CW=4 to reach counter saturation quickly).
module tb_fetch_ctrl;

  localparam int AW = 11;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          resetn;
  logic [AW-1:0] pc_cnt;
  logic          stall;
  logic          ex_branch_valid;
  logic [AW-1:0] ex_branch_target;
  logic          iret;
  logic          id_jump_valid;
  logic [AW-1:0] id_jump_target;
  logic          irq_req;
  logic          pc_branch_valid;
  logic [AW-1:0] pc_branch_address;
  logic          flush_if;
  logic          flush_id;
  logic          irq_ack;
  logic          in_isr;
  logic [AW-1:0] epc;
  logic [CW-1:0] redirect_cnt;

  int vectors = 0;
  int miscompares = 0;
  int exp_cnt = 0;

  fetch_ctrl #(
    .AW(AW), .RESET_VEC(11'h000), .IRQ_VEC(11'h7F0), .CW(CW)
  ) dut (
    .clk(clk), .resetn(resetn), .pc_cnt(pc_cnt), .stall(stall),
    .ex_branch_valid(ex_branch_valid), .ex_branch_target(ex_branch_target),
    .iret(iret), .id_jump_valid(id_jump_valid), .id_jump_target(id_jump_target),
    .irq_req(irq_req), .pc_branch_valid(pc_branch_valid),
    .pc_branch_address(pc_branch_address), .flush_if(flush_if), .flush_id(flush_id),
    .irq_ack(irq_ack), .in_isr(in_isr), .epc(epc), .redirect_cnt(redirect_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Check the combinational PC controls.
  task automatic chk_pc(input string tag, input logic v, input logic [AW-1:0] a,
                        input logic fi, input logic fd);
    chk({tag, ".valid"}, {31'd0, pc_branch_valid}, {31'd0, v});
    if (v) chk({tag, ".addr"}, {21'd0, pc_branch_address}, {21'd0, a});
    chk({tag, ".flush_if"}, {31'd0, flush_if}, {31'd0, fi});
    chk({tag, ".flush_id"}, {31'd0, flush_id}, {31'd0, fd});
  endtask

  // Advance one clock; inputs change and outputs settle away from the edge.
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic clear_inputs();
    stall = 1'b0; ex_branch_valid = 1'b0; ex_branch_target = 11'h000;
    iret = 1'b0; id_jump_valid = 1'b0; id_jump_target = 11'h000; irq_req = 1'b0;
  endtask

  initial begin
    resetn = 1'b0;
    pc_cnt = 11'h000;
    clear_inputs();
    #3;
    // Reset values
    chk_pc("rst", 1'b1, 11'h000, 1'b0, 1'b0);
    chk("rst.irq_ack", {31'd0, irq_ack}, 32'd0);
    chk("rst.in_isr", {31'd0, in_isr}, 32'd0);
    chk("rst.epc", {21'd0, epc}, 32'd0);
    chk("rst.cnt", {28'd0, redirect_cnt}, 32'd0);

    // Reset release: one BOOT cycle, then free-running increments
    step();
    resetn = 1'b1;
    #1;
    chk_pc("boot", 1'b1, 11'h000, 1'b0, 1'b0);
    step();
    chk_pc("run0", 1'b0, 11'h000, 1'b0, 1'b0);
    pc_cnt = 11'h001; #1;
    chk_pc("run1", 1'b0, 11'h000, 1'b0, 1'b0);
    step();
    pc_cnt = 11'h002; #1;
    chk_pc("run2", 1'b0, 11'h000, 1'b0, 1'b0);
    chk("run.cnt", {28'd0, redirect_cnt}, 32'd0);

    // Branch beats stall and jump
    pc_cnt = 11'h010; ex_branch_valid = 1'b1; ex_branch_target = 11'h200;
    stall = 1'b1; id_jump_valid = 1'b1; id_jump_target = 11'h300; #1;
    chk_pc("br_stall", 1'b1, 11'h200, 1'b1, 1'b1);
    step(); exp_cnt = 1;
    chk("br.cnt", {28'd0, redirect_cnt}, exp_cnt);

    // Stall hold for 3 cycles
    clear_inputs(); stall = 1'b1; pc_cnt = 11'h045;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk_pc("hold", 1'b1, 11'h045, 1'b0, 1'b0);
      step();
    end
    chk("hold.cnt", {28'd0, redirect_cnt}, exp_cnt);

    // Jump under stall is ignored (hold instead)
    id_jump_valid = 1'b1; id_jump_target = 11'h333; #1;
    chk_pc("jmp_stall", 1'b1, 11'h045, 1'b0, 1'b0);

    // iret in RUN falls through to increment
    clear_inputs(); iret = 1'b1; pc_cnt = 11'h046; #1;
    chk_pc("iret_run", 1'b0, 11'h000, 1'b0, 1'b0);
    step();
    chk("iret_run.isr", {31'd0, in_isr}, 32'd0);

    // IRQ entry
    clear_inputs(); irq_req = 1'b1; pc_cnt = 11'h123; #1;
    chk_pc("irq", 1'b1, 11'h7F0, 1'b1, 1'b0);
    step(); exp_cnt = 2;
    chk("irq.epc", {21'd0, epc}, 32'h123);
    chk("irq.ack", {31'd0, irq_ack}, 32'd1);
    chk("irq.isr", {31'd0, in_isr}, 32'd1);
    chk("irq.cnt", {28'd0, redirect_cnt}, exp_cnt);
    pc_cnt = 11'h7F0; #1;
    chk_pc("irq_nest", 1'b0, 11'h000, 1'b0, 1'b0);
    step();
    chk("irq.ack_off", {31'd0, irq_ack}, 32'd0);
    chk("irq.still_isr", {31'd0, in_isr}, 32'd1);
    chk("irq_nest.epc", {21'd0, epc}, 32'h123);

    // Return from interrupt
    clear_inputs(); iret = 1'b1; pc_cnt = 11'h7F2; #1;
    chk_pc("iret", 1'b1, 11'h123, 1'b1, 1'b1);
    step(); exp_cnt = 3;
    chk("iret.isr", {31'd0, in_isr}, 32'd0);
    chk("iret.cnt", {28'd0, redirect_cnt}, exp_cnt);

    // IRQ deferred behind a decode jump
    clear_inputs(); irq_req = 1'b1; id_jump_valid = 1'b1; id_jump_target = 11'h050;
    pc_cnt = 11'h124; #1;
    chk_pc("defer_jmp", 1'b1, 11'h050, 1'b1, 1'b0);
    step(); exp_cnt = 4;
    chk("defer.isr", {31'd0, in_isr}, 32'd0);
    id_jump_valid = 1'b0; pc_cnt = 11'h050; #1;
    chk_pc("defer_irq", 1'b1, 11'h7F0, 1'b1, 1'b0);
    step(); exp_cnt = 5;
    chk("defer.epc", {21'd0, epc}, 32'h050);
    chk("defer.isr2", {31'd0, in_isr}, 32'd1);
    chk("defer.ack", {31'd0, irq_ack}, 32'd1);

    // iret and branch together in ISR: iret wins
    clear_inputs(); iret = 1'b1; ex_branch_valid = 1'b1; ex_branch_target = 11'h222;
    pc_cnt = 11'h7F5; #1;
    chk_pc("iret_br", 1'b1, 11'h050, 1'b1, 1'b1);
    step(); exp_cnt = 6;
    chk("iret_br.isr", {31'd0, in_isr}, 32'd0);
    chk("iret_br.cnt", {28'd0, redirect_cnt}, exp_cnt);

    // Top-of-range target passes through unmodified
    clear_inputs(); id_jump_valid = 1'b1; id_jump_target = 11'h7FF; #1;
    chk_pc("jmp_max", 1'b1, 11'h7FF, 1'b1, 1'b0);

    // 20 jumps saturate the 4-bit counter at 15
    for (int i = 0; i < 20; i++) begin
      id_jump_target = 11'(i + 11'h100);
      step();
    end
    chk("sat.cnt", {28'd0, redirect_cnt}, 32'd15);

    // Reset in the middle of ISR entry cancels everything immediately
    clear_inputs(); irq_req = 1'b1; pc_cnt = 11'h0AA;
    step();
    chk("isr2.isr", {31'd0, in_isr}, 32'd1);
    chk("isr2.epc", {21'd0, epc}, 32'h0AA);
    resetn = 1'b0; #1;
    chk("mid_rst.isr", {31'd0, in_isr}, 32'd0);
    chk("mid_rst.epc", {21'd0, epc}, 32'd0);
    chk("mid_rst.cnt", {28'd0, redirect_cnt}, 32'd0);
    chk("mid_rst.ack", {31'd0, irq_ack}, 32'd0);
    chk_pc("mid_rst", 1'b1, 11'h000, 1'b0, 1'b0);
    step();
    resetn = 1'b1;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/fetch_ctrl.md
# fetch_ctrl

Fetch-stage sequencer that drives the program counter's `branch_valid`/`branch_address` inputs. It arbitrates between the competing PC sources: boot vector, execute-stage branch, decode-stage jump, interrupt entry, interrupt return and pipeline stall. It also generates the matching IF/ID flush strobes. The block sits between the hazard/branch logic and the 11-bit PC register; the PC itself only increments or loads.

## Interface
- `AW`, 11: PC/address width.
- `RESET_VEC`, 11'h000: address loaded after reset.
- `IRQ_VEC`, 11'h7F0: interrupt handler entry address.
- `CW`, 16: width of redirect statistics counter.

Ports:
- `clk`  in  1  CPU clock; all state updates on rising edge.
- `resetn`  in  1  asynchronous, active-low reset.
- `pc_cnt`  in  AW  current PC value (address in fetch).
- `stall`  in  1  hazard unit: hold fetch this cycle.
- `ex_branch_valid`  in  1  taken branch resolved in execute.
- `ex_branch_target`  in  AW  its target.
- `iret`  in  1  return-from-interrupt resolved in execute.
- `id_jump_valid`  in  1  unconditional jump decoded in ID.
- `id_jump_target`  in  AW  its target.
- `irq_req`  in  1  level interrupt request.
- `pc_branch_valid`  out  1  to PC: load `pc_branch_address` instead of incrementing.
- `pc_branch_address`  out  AW  to PC: load value.
- `flush_if`  out  1  squash instruction in IF/ID register.
- `flush_id`  out  1  squash instruction in ID/EX register.
- `irq_ack`  out  1  one-cycle interrupt acknowledge (registered).
- `in_isr`  out  1  handler active.
- `epc`  out  AW  saved return address (registered).
- `redirect_cnt`  out  CW  count of taken redirects, saturating.

## Operation
- States: BOOT, RUN, ISR. Reset forces BOOT. BOOT→RUN on the first edge after `resetn` deasserts, unconditionally. RUN↔ISR as described below. `in_isr` = (state==ISR).
- BOOT: `pc_branch_valid`=1, `pc_branch_address`=RESET_VEC, flushes 0; all other inputs ignored.
- RUN/ISR: one source wins per cycle, in this fixed priority:
  1. `iret` && ISR: redirect to `epc`; `flush_if`=`flush_id`=1; next state RUN. `iret` in RUN is ignored and falls through to lower priorities.
  2. `ex_branch_valid`: redirect to `ex_branch_target`; `flush_if`=`flush_id`=1. This wins over `stall`.
  3. IRQ entry when `irq_req` && RUN && !`stall` && !`id_jump_valid`: redirect to IRQ_VEC; `flush_if`=1, `flush_id`=0; `epc`<=`pc_cnt`; next state ISR. Entry is deferred, not dropped, while blocked.
  4. `id_jump_valid` && !`stall`: redirect to `id_jump_target`; `flush_if`=1.
  5. `stall`: `pc_branch_valid`=1, `pc_branch_address`=`pc_cnt` (hold); no flush. A jump under stall is ignored.
  6. Otherwise `pc_branch_valid`=0 (PC increments) and flushes 0.
- `iret` and `ex_branch_valid` high together in ISR is a protocol violation; `iret` wins.
- `irq_req` in ISR is ignored; there is no nesting.
- `redirect_cnt` increments by 1 on each cycle where cases 1-4 fire. It saturates at 2^CW-1 and is not incremented by stall holds or BOOT.
- Address arithmetic is none; targets pass through unmodified, mod 2^AW.

## Timing
- `pc_branch_valid`, `pc_branch_address`, `flush_if` and `flush_id` are combinational from the current state and inputs, so the PC loads on the same edge. Redirect latency is 0 cycles: the new PC is visible the cycle after the request.
- `epc`, state, `redirect_cnt` and `irq_ack` are registered. `irq_ack` is high for exactly the one cycle after the entry edge.
- Reset values (asynchronous, while `resetn`=0):
  - `pc_branch_valid`=1, `pc_branch_address`=RESET_VEC.
  - `flush_if`=`flush_id`=0, `irq_ack`=0, `in_isr`=0.
  - `epc`=0, `redirect_cnt`=0.
- Reset mid-ISR: return to BOOT immediately. `epc` and `in_isr` clear, and a pending `irq_ack` is cancelled.

## Test plan
- Reset release: `resetn` 0→1 → one BOOT cycle with `pc_branch_address`=0x000, then RUN. PC counts 0,1,2,… with `pc_branch_valid`=0.
- Branch vs stall: at `pc_cnt`=0x010, assert `ex_branch_valid`=1 (target 0x200) together with `stall`=1 and `id_jump_valid`=1 (target 0x300) → PC=0x200 next cycle, `flush_if`=`flush_id`=1, `redirect_cnt`+1.
- Stall hold: `stall`=1 for 3 cycles at `pc_cnt`=0x045 → PC stays 0x045 for 3 cycles, no flushes, `redirect_cnt` unchanged.
- IRQ entry/return: `irq_req`=1 at `pc_cnt`=0x123 with no hazards → next PC 0x7F0, `epc`=0x123, `irq_ack` pulses one cycle, `in_isr`=1. Second `irq_req` is ignored. Later `iret` → PC 0x123, `in_isr`=0.
- IRQ deferral: `irq_req` rises while `id_jump_valid`=1 (target 0x050) → jump taken first, PC=0x050. Entry occurs the next cycle with `epc`=0x050.
- Saturation/reset: with CW=4, issue 20 jumps → `redirect_cnt`=15. Assert `resetn`=0 mid-ISR → `in_isr`=0, `epc`=0, `redirect_cnt`=0 immediately.
